// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues word reads, buffers responses in an
// in-order prefetch FIFO, and flushes/discards stale responses on redirect.
module ifetch_queue #(
  parameter int              AW       = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          nreset,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  input  logic          rsp_valid,
  input  logic [31:0]   rsp_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [AW-1:0] fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] live, discard;
  logic [TW-1:0] tag_rd, tag_wr;
  logic [31:0]   last_data;
  logic [AW-1:0] last_pc;

  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [AW-1:0] tag_mem  [MAX_OUT];

  logic issue, push, pop;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Never issue past what the FIFO could absorb, so responses always have room.
  always_comb begin
    req_valid  = nreset && !redir_valid &&
                 (32'(count) + 32'(live) < 32'(DEPTH)) &&
                 (32'(live) + 32'(discard) < 32'(MAX_OUT));
    req_addr   = fetch_pc;
    issue      = req_valid && req_ready;
    push       = nreset && !redir_valid && rsp_valid && (discard == '0);
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready;
    inst_data  = inst_valid ? data_mem[rd_ptr] : last_data;
    inst_pc    = inst_valid ? pc_mem[rd_ptr]   : last_pc;
    busy       = (live != '0) || (discard != '0);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      live      <= '0;
      discard   <= '0;
      tag_rd    <= '0;
      tag_wr    <= '0;
      last_data <= '0;
      last_pc   <= '0;
    end else if (redir_valid) begin
      // Everything in flight becomes stale; a response arriving now retires one of them.
      fetch_pc <= redir_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      live     <= '0;
      discard  <= discard + live - OW'(rsp_valid);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + AW'(1);
        tag_wr   <= tag_next(tag_wr);
      end
      if (rsp_valid && (discard != '0))
        discard <= discard - OW'(1);
      if (push) begin
        tag_rd <= tag_next(tag_rd);
        wr_ptr <= wr_ptr + PW'(1);
      end
      live  <= live + OW'(issue) - OW'(push);
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_data <= data_mem[rd_ptr];
        last_pc   <= pc_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= rsp_data;
      pc_mem[wr_ptr]   <= tag_mem[tag_rd];
    end
    if (issue)
      tag_mem[tag_wr] <= fetch_pc;
  end

  // A response with nothing outstanding means the memory side is broken.
  always_ff @(posedge clk) begin
    if (nreset)
      assert (!(rsp_valid && (live == '0) && (discard == '0)));
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model with variable
// latency, expected instruction stream derived from redirect/reset targets.
module tb_ifetch_queue;

  localparam int AW = 32;

  logic          clk, nreset;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          inst_valid, inst_ready;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic          busy;

  ifetch_queue #(.AW(AW), .DEPTH(4), .MAX_OUT(2), .RESET_PC('0)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int last_due = 0;
  int n_req = 0, n_pop = 0;
  int first_req = -1, first_inst = -1;
  bit saw0 = 0;

  typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
  mreq_t         memq[$];
  logic [AW-1:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000 + a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Expected delivery after a reset or redirect: consecutive word addresses.
  task automatic exp_reset(input logic [AW-1:0] pc);
    exp_q.delete();
    for (int i = 0; i < 2048; i++) exp_q.push_back(pc + AW'(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: in-order responses at or after their due cycle, one per cycle.
  always begin
    @(posedge clk);
    #1;
    if (!nreset) begin
      memq.delete();
      last_due  = 0;
      rsp_valid = 0;
      rsp_data  = '0;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_valid = 1;
      rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      rsp_valid = 0;
      rsp_data  = $urandom;
    end
  end

  // Monitor: records request handshakes and checks every delivered instruction.
  always @(negedge clk) begin
    if (nreset) begin
      if (req_valid && first_req < 0) first_req = cyc;
      if (req_valid && req_ready) begin
        mreq_t m;
        int d;
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        m.addr = req_addr;
        m.due  = d;
        memq.push_back(m);
        n_req++;
        if (req_addr == '0) saw0 = 1;
      end
      if (inst_valid && inst_ready && !redir_valid) begin
        n_pop++;
        if (first_inst < 0) first_inst = cyc;
        if (exp_q.size() == 0) begin
          chk("sb_empty", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [AW-1:0] e;
          e = exp_q.pop_front();
          chk("inst_pc", 64'(inst_pc), 64'(e));
          chk("inst_data", 64'(inst_data), 64'(mem_word(e)));
        end
      end
    end
  end

  task automatic do_redirect(input logic [AW-1:0] pc);
    redir_valid = 1;
    redir_pc    = pc;
    exp_reset(pc);
    tick();
    redir_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      tick();
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    nreset = 0;
    tick(); tick(); tick();
  endtask

  initial begin
    int n0;
    bit found;
    nreset = 0; req_ready = 1; inst_ready = 1; redir_valid = 0; redir_pc = '0;
    rsp_valid = 0; rsp_data = '0;
    do_reset();
    chk("rst_req_valid", 64'(req_valid), 0);
    chk("rst_inst_valid", 64'(inst_valid), 0);
    chk("rst_inst_data", 64'(inst_data), 0);
    chk("rst_inst_pc", 64'(inst_pc), 0);
    chk("rst_busy", 64'(busy), 0);

    // Streaming from reset with 1-cycle memory
    lat = 1; first_req = -1; first_inst = -1; n0 = n_pop;
    exp_reset('0);
    nreset = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("startup_latency", 64'(first_inst - first_req), 2);
    chk("stream_count", 64'(n_pop - n0), 18);

    // Backpressure fills exactly DEPTH entries
    do_reset();
    exp_reset('0);
    inst_ready = 0; n_req = 0;
    nreset = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_requests", 64'(n_req), 4);
    chk("bp_req_valid", 64'(req_valid), 0);
    chk("bp_inst_valid", 64'(inst_valid), 1);
    chk("bp_head_pc", 64'(inst_pc), 0);
    chk("bp_busy", 64'(busy), 0);
    n0 = n_pop;
    inst_ready = 1;
    for (int i = 0; i < 12; i++) tick();
    chk("bp_drain", 64'(n_pop - n0 >= 8), 1);

    // Redirect with latency 3 and requests in flight
    lat = 3;
    for (int i = 0; i < 8; i++) tick();
    chk("l3_busy", 64'(busy), 1);
    req_ready = 0;
    do_redirect(32'h40);
    chk("l3_redir_inst_valid", 64'(inst_valid), 0);
    wait_idle("l3_drain");
    req_ready = 1; n0 = n_pop;
    for (int i = 0; i < 15; i++) tick();
    chk("l3_progress", 64'(n_pop > n0), 1);

    // Redirect coinciding with a response and a pop
    lat = 1; inst_ready = 0;
    tick(); tick();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid && inst_valid) begin found = 1; break; end
      tick();
    end
    chk("coinc_setup", 64'(found), 1);
    inst_ready = 1;
    do_redirect(32'h80);
    chk("coinc_inst_valid", 64'(inst_valid), 0);
    n0 = n_pop;
    for (int i = 0; i < 10; i++) tick();
    chk("coinc_progress", 64'(n_pop > n0), 1);

    // Back-to-back redirects
    lat = 3;
    for (int i = 0; i < 6; i++) tick();
    redir_valid = 1; redir_pc = 32'h10; exp_reset(32'h10);
    tick();
    req_ready = 0;
    do_redirect(32'h20);
    chk("b2b_inst_valid", 64'(inst_valid), 0);
    wait_idle("b2b_drain");
    req_ready = 1; n0 = n_pop;
    for (int i = 0; i < 12; i++) tick();
    chk("b2b_progress", 64'(n_pop > n0), 1);

    // Fetch PC wrap
    lat = 1; saw0 = 0;
    do_redirect(32'hFFFF_FFFE);
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_addr0", 64'(saw0), 1);

    // Randomized traffic
    n0 = n_pop;
    for (int i = 0; i < 1500; i++) begin
      req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      lat        = $urandom_range(1, 4);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0) do_redirect(32'hFFFF_FFFC + AW'($urandom_range(0, 3)));
        else do_redirect($urandom);
      end else begin
        tick();
      end
    end
    chk("rand_progress", 64'(n_pop - n0 > 300), 1);
    req_ready = 0;
    wait_idle("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
